mp_add_seq: RTL and testbench

MP_ADD_SEQ -- requirements
Module: mp_add_seq

---
 rtl/mp_add_seq.sv | 194 +++++++++++++++++++
 tb/tb_mp_add_seq.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mp_add_seq.sv
// mp_add_seq
// ----------
// Sequential multi-precision adder/subtractor. A single Width-bit
// carry-lookahead adder is time-shared across the Words words of an
// operation. Operand words arrive least-significant first through a
// valid/ready input handshake. Result words leave through a valid/ready
// output handshake with one cycle of latency. The carry chains from word to
// word through a carry register.
//
// Configuration macro: MP_ADD_SEQ_SUB_EN
//   defined   : sub_i selects subtraction (A + ~B + 1). A final carry_o of 1
//               means no borrow.
//   undefined : sub_i is ignored. Every operation is an add with carry-in 0.
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   start_i      begin an operation (sampled in IDLE only)
//   sub_i        0 = add, 1 = subtract (sampled with start_i)
//   in_valid_i   operand word pair valid
//   in_ready_o   operand word pair accepted
//   a_i, b_i     operand words, LSW first
//   out_valid_o  result word valid
//   out_ready_i  downstream accepts result word
//   result_o     result word
//   last_o       final result word marker
//   carry_o      final carry, only with last_o
//   busy_o       operation in progress (any state but IDLE)

module mp_add_seq #(
  parameter int Width = 4,
  parameter int Words = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             sub_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [Width-1:0] result_o,
  output logic             last_o,
  output logic             carry_o,
  output logic             busy_o
);

  localparam int CntW = (Words > 1) ? $clog2(Words) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(Words - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              carry_q, carry_d;
  logic [Width-1:0]  result_q, result_d;
  logic              out_valid_q, out_valid_d;
  logic              last_q, last_d;
  logic              carry_out_q, carry_out_d;

`ifdef MP_ADD_SEQ_SUB_EN
  logic              op_q, op_d;
`else
  logic              sub_unused;
  assign sub_unused = sub_i;
`endif

  logic [Width-1:0]  cla_b, gen, prop, sum;
  logic [Width:0]    cy;
  logic              la_acc, la_chain;
  logic              in_xfer, out_xfer;

  // Carry-lookahead adder shared by every word. Each carry is built directly
  // from the generate/propagate terms of all lower bits and the carry-in.
  // It is not rippled from the carry just below it. For subtraction, B is
  // inverted and the carry register starts at 1, which forms the two's
  // complement.
  always_comb begin
`ifdef MP_ADD_SEQ_SUB_EN
    cla_b = op_q ? ~b_i : b_i;
`else
    cla_b = b_i;
`endif
    gen      = a_i & cla_b;
    prop     = a_i ^ cla_b;
    cy       = '0;
    cy[0]    = carry_q;
    la_acc   = 1'b0;
    la_chain = 1'b0;
    for (int i = 0; i < Width; i++) begin
      la_acc   = gen[i];
      la_chain = prop[i];
      for (int j = i - 1; j >= 0; j--) begin
        la_acc   = la_acc | (la_chain & gen[j]);
        la_chain = la_chain & prop[j];
      end
      cy[i+1] = la_acc | (la_chain & cy[0]);
    end
    sum = prop ^ cy[Width-1:0];
  end

  assign in_ready_o = (state_q == RUN) && (!out_valid_q || out_ready_i);
  assign in_xfer    = in_valid_i && in_ready_o;
  assign out_xfer   = out_valid_q && out_ready_i;

  // Next-state and datapath control. The state transitions are decided in
  // the case statement. The output register then either loads a new word
  // (input transfer) or empties (output transfer only). When both happen in
  // one cycle, the new word replaces the old one with no bubble.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;
    last_d      = last_q;
    carry_out_d = carry_out_q;
`ifdef MP_ADD_SEQ_SUB_EN
    op_d        = op_q;
`endif

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = RUN;
          cnt_d   = '0;
`ifdef MP_ADD_SEQ_SUB_EN
          carry_d = sub_i;
          op_d    = sub_i;
`else
          carry_d = 1'b0;
`endif
        end
      end
      RUN: begin
        if (in_xfer && (cnt_q == LastCnt)) state_d = DRAIN;
      end
      DRAIN: begin
        if (out_xfer && last_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (in_xfer) begin
      result_d    = sum;
      out_valid_d = 1'b1;
      carry_d     = cy[Width];
      cnt_d       = cnt_q + CntW'(1);
      last_d      = (cnt_q == LastCnt);
      carry_out_d = (cnt_q == LastCnt) ? cy[Width] : 1'b0;
    end else if (out_xfer) begin
      out_valid_d = 1'b0;
      last_d      = 1'b0;
      carry_out_d = 1'b0;
    end
  end

  // State and datapath registers. Reset has priority over every input and
  // aborts any operation in progress.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      last_q      <= 1'b0;
      carry_out_q <= 1'b0;
`ifdef MP_ADD_SEQ_SUB_EN
      op_q        <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      last_q      <= last_d;
      carry_out_q <= carry_out_d;
`ifdef MP_ADD_SEQ_SUB_EN
      op_q        <= op_d;
`endif
    end
  end

  assign out_valid_o = out_valid_q;
  assign result_o    = result_q;
  assign last_o      = last_q;
  assign carry_o     = carry_out_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_mp_add_seq.sv
// tb_mp_add_seq
// -------------
// Testbench for mp_add_seq with Width=4 and Words=2. It runs directed
// operations, a stall, a start pulse during RUN, a reset abort, and then
// random operations with random handshakes. Each operation's expected
// words and final carry come from plain integer arithmetic on the full
// 8-bit operands.
// Subtraction is expected only when MP_ADD_SEQ_SUB_EN is defined.

module tb_mp_add_seq;

  localparam int W = 4;
  localparam int N = 2;

`ifdef MP_ADD_SEQ_SUB_EN
  localparam bit SubEn = 1'b1;
`else
  localparam bit SubEn = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_i = 1'b0;
  logic         start_i = 1'b0;
  logic         sub_i = 1'b0;
  logic         in_valid_i = 1'b0;
  logic         in_ready_o;
  logic [W-1:0] a_i = '0;
  logic [W-1:0] b_i = '0;
  logic         out_valid_o;
  logic         out_ready_i = 1'b0;
  logic [W-1:0] result_o;
  logic         last_o;
  logic         carry_o;
  logic         busy_o;

  int check_count = 0;
  int error_count = 0;

  mp_add_seq #(.Width(W), .Words(N)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .sub_i       (sub_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .a_i         (a_i),
    .b_i         (b_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .result_o    (result_o),
    .last_o      (last_o),
    .carry_o     (carry_o),
    .busy_o      (busy_o)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Single comparison point: counts the comparison and reports a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Runs one whole operation. It is entered and left one time unit after
  // a rising edge. The expected output comes from integer arithmetic on the
  // full operands. A subtract is computed as 256 + A - B, so bit 8 is the
  // no-borrow flag. The bench tracks how many words it has sent and
  // received, and from those counts it derives the expected
  // valid/ready/busy levels.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input bit sub,
                               input int stall, input bit rand_bp, input bit pulse_start);
    int         full;
    logic [7:0] exp_words;
    logic       exp_cy;
    int         sent, recv, stall_left, cycles;
    bit         stall_done, exp_valid, exp_ready;

    full      = (sub && SubEn) ? (256 + int'(a) - int'(b)) : (int'(a) + int'(b));
    exp_words = full[7:0];
    exp_cy    = full[8];

    start_i = 1'b1;
    sub_i   = sub;
    @(posedge clk); #1;
    start_i = 1'b0;

    sent = 0; recv = 0; stall_left = 0; cycles = 0; stall_done = 0;
    while (recv < N && cycles < 200) begin
      in_valid_i = (sent < N) && (rand_bp ? ($urandom % 2 == 1) : 1'b1);
      if (sent < N) begin
        a_i = a[sent*W +: W];
        b_i = b[sent*W +: W];
      end else begin
        a_i = W'($urandom);
        b_i = W'($urandom);
      end
      exp_valid = (sent > recv);
      if (exp_valid && recv == 0 && !stall_done && stall > 0) begin
        stall_left = stall;
        stall_done = 1'b1;
      end
      out_ready_i = (stall_left > 0) ? 1'b0 : (rand_bp ? ($urandom % 2 == 1) : 1'b1);
      if (stall_left > 0) stall_left--;
      start_i = pulse_start && (cycles == 1);
      sub_i   = 1'($urandom);
      #1;
      exp_ready = (sent < N) && (!exp_valid || out_ready_i);
      checkOutput("busy", 32'(busy_o), 32'd1);
      checkOutput("out_valid", 32'(out_valid_o), 32'(exp_valid));
      checkOutput("in_ready", 32'(in_ready_o), 32'(exp_ready));
      if (exp_valid) begin
        checkOutput("result", 32'(result_o), 32'(exp_words[recv*W +: W]));
        checkOutput("last", 32'(last_o), 32'(recv == N - 1));
        checkOutput("carry", 32'(carry_o), (recv == N - 1) ? 32'(exp_cy) : 32'd0);
      end
      if (in_valid_i && exp_ready) sent++;
      if (exp_valid && out_ready_i) recv++;
      @(posedge clk); #1;
      cycles++;
    end
    if (recv < N) checkOutput("op_timeout", 32'd1, 32'd0);
    start_i     = 1'b0;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    checkOutput("busy_end", 32'(busy_o), 32'd0);
    checkOutput("out_valid_end", 32'(out_valid_o), 32'd0);
  endtask

  // Hard stop in case the bench itself wedges.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] global timeout");
  end

  // Main sequence: reset state, directed cases, reset abort, random ops.
  initial begin
    rst_i = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst_i = 1'b0;
    checkOutput("rst_out_valid", 32'(out_valid_o), 32'd0);
    checkOutput("rst_busy", 32'(busy_o), 32'd0);
    checkOutput("rst_result", 32'(result_o), 32'd0);
    checkOutput("rst_last", 32'(last_o), 32'd0);
    checkOutput("rst_carry", 32'(carry_o), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready_o), 32'd0);

    $display("[TB] directed add/sub cases");
    applyStimulus(8'h3F, 8'h01, 1'b0, 0, 1'b0, 1'b0);
    applyStimulus(8'hFF, 8'h01, 1'b0, 0, 1'b0, 1'b0);
    applyStimulus(8'h10, 8'h01, 1'b1, 0, 1'b0, 1'b0);
    applyStimulus(8'h00, 8'h01, 1'b1, 0, 1'b0, 1'b0);

    $display("[TB] output stall and start pulse during RUN");
    applyStimulus(8'h3F, 8'h01, 1'b0, 3, 1'b0, 1'b0);
    applyStimulus(8'h3F, 8'h01, 1'b0, 0, 1'b0, 1'b1);

    $display("[TB] reset abort after first input transfer");
    start_i = 1'b1;
    sub_i   = 1'b0;
    @(posedge clk); #1;
    start_i     = 1'b0;
    in_valid_i  = 1'b1;
    a_i         = 4'hF;
    b_i         = 4'h1;
    out_ready_i = 1'b1;
    @(posedge clk); #1;
    checkOutput("abort_pre_valid", 32'(out_valid_o), 32'd1);
    in_valid_i = 1'b0;
    rst_i      = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    checkOutput("abort_out_valid", 32'(out_valid_o), 32'd0);
    checkOutput("abort_busy", 32'(busy_o), 32'd0);
    checkOutput("abort_result", 32'(result_o), 32'd0);
    @(posedge clk); #1;
    checkOutput("abort_no_more", 32'(out_valid_o), 32'd0);
    out_ready_i = 1'b0;
    applyStimulus(8'h3F, 8'h01, 1'b0, 0, 1'b0, 1'b0);

    $display("[TB] random operations");
    for (int k = 0; k < 30; k++) begin
      applyStimulus(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 2)),
                    1'b1, 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
